// File: rtl/packet_loader_ctrl_pkg.sv
// Shared definitions for the packet loader and the grid controller:
// the phase FSM encoding and its width.
package packet_loader_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'b000,
    LOAD     = 3'b001,
    COMPUTE  = 3'b010,
    WAIT_END = 3'b100
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy-based flags and a registered read port.
// A write that cannot be accepted is reported on wdrop_o for the caller to log.
module sync_fifo #(
  parameter int DSIZE = 30,
  parameter int ASIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc_i,
  input  logic [DSIZE-1:0] wdata_i,
  output logic             wfull_o,
  input  logic             ren_i,
  output logic [DSIZE-1:0] rdata_o,
  output logic             empty_o,
  output logic             wdrop_o
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE-1:0] wptr_q, rptr_q;
  logic [ASIZE:0]   count_q;
  logic [DSIZE-1:0] rdata_q;
  logic             rd_ok, wr_ok;

  assign empty_o = (count_q == '0);
  assign wfull_o = (count_q == (ASIZE+1)'(DEPTH));

  // A read frees a slot in the same cycle, so a write at full is accepted alongside it.
  assign rd_ok   = ren_i && !empty_o;
  assign wr_ok   = winc_i && (!wfull_o || rd_ok);
  assign wdrop_o = winc_i && !wr_ok;
  assign rdata_o = rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) begin
        rptr_q  <= rptr_q + 1'b1;
        rdata_q <= mem_q[rptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/packet_loader_ctrl.sv
// Packet loader: buffers grid packets, sequences load/compute/drain phases and
// gathers per-channel spike IDs into one frame per tick.
module packet_loader_ctrl
  import packet_loader_ctrl_pkg::*;
#(
  parameter int PKT_W       = 30,
  parameter int ASIZE       = 8,
  parameter int NUM_NEURONS = 250,
  parameter int ID_W        = 8,
  parameter int NUM_CH      = 2,
  parameter int END_TICKS   = 2,
  parameter int FCNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pkt_winc,
  input  logic [PKT_W-1:0]       pkt_wdata,
  output logic                   pkt_wfull,
  input  logic                   pkt_ren,
  output logic [PKT_W-1:0]       pkt_rdata,
  output logic                   pkt_empty,
  input  logic                   tick,
  input  logic [NUM_CH-1:0]      spk_valid,
  input  logic [NUM_CH*ID_W-1:0] spk_id,
  input  logic                   grid_done,
  input  logic                   load_end,
  input  logic                   spike_en,
  output logic [STATE_W-1:0]     state,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   frame_valid,
  output logic [FCNT_W-1:0]      frame_cnt,
  output logic                   complete,
  output logic                   err_ovf,
  output logic                   err_range
);

  localparam int IDX_W  = $clog2(NUM_NEURONS);
  localparam int ECNT_W = $clog2(END_TICKS + 1);

  state_e                   state_q, state_d;
  logic [NUM_NEURONS-1:0]   acc_q, acc_d, spike_out_q;
  logic                     frame_valid_q;
  logic [FCNT_W-1:0]        frame_cnt_q;
  logic                     complete_q, complete_d;
  logic                     err_ovf_q, err_range_q;
  logic [ECNT_W-1:0]        end_cnt_q, end_cnt_d;
  logic                     capture, range_hit, wdrop;

  sync_fifo #(
    .DSIZE (PKT_W),
    .ASIZE (ASIZE)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .winc_i  (pkt_winc),
    .wdata_i (pkt_wdata),
    .wfull_o (pkt_wfull),
    .ren_i   (pkt_ren),
    .rdata_o (pkt_rdata),
    .empty_o (pkt_empty),
    .wdrop_o (wdrop)
  );

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_d     = tick ? '0 : acc_q;
    range_hit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (spk_valid[c]) begin
        if (int'(spk_id[c*ID_W +: ID_W]) < NUM_NEURONS)
          acc_d[IDX_W'(NUM_NEURONS - 1 - int'(spk_id[c*ID_W +: ID_W]))] = 1'b1;
        else
          range_hit = 1'b1;
      end
    end
  end

  assign capture = tick && (((state_q == COMPUTE) && spike_en) || (state_q == WAIT_END));

  always_comb begin
    state_d    = state_q;
    complete_d = complete_q;
    end_cnt_d  = end_cnt_q;
    case (state_q)
      IDLE: begin
        if (!pkt_empty) begin
          state_d    = LOAD;
          complete_d = 1'b0;
        end
      end
      LOAD: begin
        if (pkt_empty) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (load_end)       state_d = WAIT_END;
        else if (grid_done) state_d = LOAD;
      end
      WAIT_END: begin
        if (tick) begin
          if (end_cnt_q == ECNT_W'(END_TICKS - 1)) begin
            complete_d = 1'b1;
            end_cnt_d  = '0;
            state_d    = IDLE;
          end else begin
            end_cnt_d = end_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      spike_out_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      complete_q    <= 1'b0;
      end_cnt_q     <= '0;
      err_ovf_q     <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      complete_q    <= complete_d;
      end_cnt_q     <= end_cnt_d;
      acc_q         <= acc_d;
      frame_valid_q <= capture;
      // The published frame is the one closed by this tick, not the one it opens.
      if (capture) begin
        spike_out_q <= acc_q;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      err_ovf_q   <= err_ovf_q | wdrop;
      err_range_q <= err_range_q | range_hit;
    end
  end

  assign state       = state_q;
  assign spike_out   = spike_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign complete    = complete_q;
  assign err_ovf     = err_ovf_q;
  assign err_range   = err_range_q;

endmodule

// File: tb/tb_packet_loader_ctrl.sv
// Bench for packet_loader_ctrl: a queue/bit-vector reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_packet_loader_ctrl;

  localparam int PKT_W = 30, ASIZE = 8, NN = 250, ID_W = 8, NUM_CH = 2;
  localparam int END_TICKS = 2, FCNT_W = 16, DEPTH = 256;
  localparam logic [2:0] S_IDLE = 3'b000, S_LOAD = 3'b001, S_COMPUTE = 3'b010, S_WAIT = 3'b100;

  logic                   clk, reset_n;
  logic                   pkt_winc, pkt_ren, tick, grid_done, load_end, spike_en;
  logic [PKT_W-1:0]       pkt_wdata, pkt_rdata;
  logic                   pkt_wfull, pkt_empty;
  logic [NUM_CH-1:0]      spk_valid;
  logic [NUM_CH*ID_W-1:0] spk_id;
  logic [2:0]             state;
  logic [NN-1:0]          spike_out;
  logic                   frame_valid, complete, err_ovf, err_range;
  logic [FCNT_W-1:0]      frame_cnt;

  packet_loader_ctrl #(
    .PKT_W(PKT_W), .ASIZE(ASIZE), .NUM_NEURONS(NN), .ID_W(ID_W),
    .NUM_CH(NUM_CH), .END_TICKS(END_TICKS), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pkt_winc(pkt_winc), .pkt_wdata(pkt_wdata), .pkt_wfull(pkt_wfull),
    .pkt_ren(pkt_ren), .pkt_rdata(pkt_rdata), .pkt_empty(pkt_empty),
    .tick(tick), .spk_valid(spk_valid), .spk_id(spk_id),
    .grid_done(grid_done), .load_end(load_end), .spike_en(spike_en),
    .state(state), .spike_out(spike_out), .frame_valid(frame_valid),
    .frame_cnt(frame_cnt), .complete(complete),
    .err_ovf(err_ovf), .err_range(err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame as a plain bit vector.
  logic [PKT_W-1:0] m_q[$];
  logic [PKT_W-1:0] m_rdata;
  logic [2:0]       m_state;
  logic [NN-1:0]    m_acc, m_spk;
  logic             m_fv, m_complete, m_ovf, m_rng;
  logic [FCNT_W-1:0] m_fcnt;
  int               m_ticks;

  task automatic model_reset();
    m_q.delete();
    m_rdata = '0; m_state = S_IDLE; m_acc = '0; m_spk = '0;
    m_fv = 1'b0; m_complete = 1'b0; m_ovf = 1'b0; m_rng = 1'b0;
    m_fcnt = '0; m_ticks = 0;
  endtask

  task automatic model_step();
    bit was_empty, rd, wr, cap;
    int id;
    was_empty = (m_q.size() == 0);
    rd = pkt_ren && !was_empty;
    wr = pkt_winc && ((m_q.size() < DEPTH) || rd);
    if (pkt_winc && !wr) m_ovf = 1'b1;
    if (rd) m_rdata = m_q.pop_front();
    if (wr) m_q.push_back(pkt_wdata);

    cap = tick && (((m_state == S_COMPUTE) && spike_en) || (m_state == S_WAIT));
    m_fv = cap;
    if (cap) begin
      m_spk  = m_acc;
      m_fcnt = m_fcnt + 1'b1;
    end
    if (tick) m_acc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      id = int'(spk_id[c*ID_W +: ID_W]);
      if (spk_valid[c]) begin
        if (id < NN) m_acc[NN-1-id] = 1'b1;
        else         m_rng = 1'b1;
      end
    end

    case (m_state)
      S_IDLE:    if (!was_empty) begin m_state = S_LOAD; m_complete = 1'b0; end
      S_LOAD:    if (was_empty) m_state = S_COMPUTE;
      S_COMPUTE: if (load_end) m_state = S_WAIT; else if (grid_done) m_state = S_LOAD;
      S_WAIT: if (tick) begin
        m_ticks++;
        if (m_ticks == END_TICKS) begin
          m_complete = 1'b1; m_ticks = 0; m_state = S_IDLE;
        end
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("m_state",       state,       m_state);
    check("m_empty",       pkt_empty,   m_q.size() == 0);
    check("m_wfull",       pkt_wfull,   m_q.size() == DEPTH);
    check("m_rdata",       pkt_rdata,   m_rdata);
    check("m_spike_out",   spike_out,   m_spk);
    check("m_frame_valid", frame_valid, m_fv);
    check("m_frame_cnt",   frame_cnt,   m_fcnt);
    check("m_complete",    complete,    m_complete);
    check("m_err_ovf",     err_ovf,     m_ovf);
    check("m_err_range",   err_range,   m_rng);
  endtask

  always @(posedge clk) begin
    if (!reset_n) model_reset();
    else          model_step();
    #1;
    compare_all();
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    pkt_winc = 1'b0; pkt_wdata = '0; pkt_ren = 1'b0; tick = 1'b0;
    spk_valid = '0; spk_id = '0; grid_done = 1'b0; load_end = 1'b0; spike_en = 1'b0;
  endtask

  logic [NN-1:0] e;

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    cyc(2);
    check("rst_empty", pkt_empty, 1'b1);
    check("rst_wfull", pkt_wfull, 1'b0);
    check("rst_state", state, S_IDLE);
    check("rst_rdata", pkt_rdata, '0);
    check("rst_fcnt",  frame_cnt, '0);
    reset_n = 1'b1;

    // Three packets in, three out, in order.
    pkt_winc = 1'b1; pkt_wdata = 30'h0000_0A1; cyc();
    pkt_wdata = 30'h0000_0B2; cyc();
    pkt_wdata = 30'h0000_0C3; cyc();
    pkt_winc = 1'b0;
    check("t1_state_load", state, S_LOAD);
    pkt_ren = 1'b1; cyc(); check("t1_rd0", pkt_rdata, 30'h0A1);
    cyc(); check("t1_rd1", pkt_rdata, 30'h0B2);
    cyc(); check("t1_rd2", pkt_rdata, 30'h0C3);
    check("t1_empty", pkt_empty, 1'b1);
    pkt_ren = 1'b0; cyc();
    check("t1_state_compute", state, S_COMPUTE);

    // Frame with ids 0 and 5.
    spike_en = 1'b1;
    spk_valid = 2'b11; spk_id = {8'd5, 8'd0}; cyc();
    spk_valid = '0; tick = 1'b1; cyc(); tick = 1'b0;
    e = '0; e[249] = 1'b1; e[244] = 1'b1;
    check("t2_frame", spike_out, e);
    check("t2_fv", frame_valid, 1'b1);
    check("t2_fcnt", frame_cnt, 16'd1);
    cyc(); check("t2_fv_drop", frame_valid, 1'b0);

    // Spike on the tick cycle belongs to the next frame.
    spk_valid = 2'b01; spk_id = {8'd0, 8'd7}; tick = 1'b1; cyc();
    spk_valid = '0; tick = 1'b0;
    check("t3_frame_empty", spike_out, '0);
    check("t3_fcnt", frame_cnt, 16'd2);
    tick = 1'b1; cyc(); tick = 1'b0;
    e = '0; e[242] = 1'b1;
    check("t3_frame_next", spike_out, e);
    check("t3_fcnt2", frame_cnt, 16'd3);

    // Out-of-range id flags an error and leaves the frame alone.
    spk_valid = 2'b11; spk_id = {8'd250, 8'd1}; cyc(); spk_valid = '0;
    check("t4_err_range", err_range, 1'b1);
    tick = 1'b1; cyc(); tick = 1'b0;
    e = '0; e[248] = 1'b1;
    check("t4_frame", spike_out, e);

    // Duplicate ids across channels collapse to one bit.
    spk_valid = 2'b11; spk_id = {8'd3, 8'd3}; cyc(); spk_valid = '0;
    tick = 1'b1; cyc(); tick = 1'b0;
    e = '0; e[246] = 1'b1;
    check("t4_dup", spike_out, e);
    check("t4_fcnt", frame_cnt, 16'd5);

    // spike_en=0: tick clears without capturing.
    spike_en = 1'b0;
    spk_valid = 2'b01; spk_id = {8'd0, 8'd9}; cyc(); spk_valid = '0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("t4_nocap_fcnt", frame_cnt, 16'd5);
    check("t4_nocap_fv", frame_valid, 1'b0);

    // grid_done returns to LOAD; empty FIFO drops straight back to COMPUTE.
    grid_done = 1'b1; cyc(); grid_done = 1'b0;
    check("t5_load", state, S_LOAD);
    cyc(); check("t5_compute", state, S_COMPUTE);

    // load_end wins over grid_done; two ticks finish the run.
    load_end = 1'b1; grid_done = 1'b1; cyc(); load_end = 1'b0; grid_done = 1'b0;
    check("t5_wait", state, S_WAIT);
    spk_valid = 2'b01; spk_id = {8'd0, 8'd20}; cyc(); spk_valid = '0;
    tick = 1'b1; cyc(); tick = 1'b0;
    e = '0; e[229] = 1'b1;
    check("t5_cap1", spike_out, e);
    check("t5_cap1_cnt", frame_cnt, 16'd6);
    check("t5_not_done", complete, 1'b0);
    cyc(); tick = 1'b1; cyc(); tick = 1'b0;
    check("t5_cap2", spike_out, '0);
    check("t5_cap2_cnt", frame_cnt, 16'd7);
    check("t5_complete", complete, 1'b1);
    check("t5_idle", state, S_IDLE);
    load_end = 1'b1; tick = 1'b1; cyc(); load_end = 1'b0; tick = 1'b0;
    check("t5_idle_hold", state, S_IDLE);
    check("t5_idle_cnt", frame_cnt, 16'd7);
    pkt_winc = 1'b1; pkt_wdata = 30'h1234; cyc(); pkt_winc = 1'b0;
    check("t5_complete_sticky", complete, 1'b1);
    cyc();
    check("t5_relaunch", state, S_LOAD);
    check("t5_complete_clr", complete, 1'b0);
    pkt_ren = 1'b1; cyc(); pkt_ren = 1'b0;
    check("t5_rd", pkt_rdata, 30'h1234);
    cyc(); check("t5_back_compute", state, S_COMPUTE);

    // Fill to full, overflow, read+write at full, drain.
    pkt_winc = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pkt_wdata = PKT_W'(100 + i); cyc();
    end
    check("t6_full", pkt_wfull, 1'b1);
    check("t6_no_ovf_yet", err_ovf, 1'b0);
    pkt_wdata = 30'd999; cyc();
    check("t6_ovf", err_ovf, 1'b1);
    pkt_wdata = 30'd777; pkt_ren = 1'b1; cyc(); pkt_winc = 1'b0;
    check("t6_rw_rd", pkt_rdata, 30'd100);
    check("t6_rw_full", pkt_wfull, 1'b1);
    cyc(DEPTH);
    check("t6_last", pkt_rdata, 30'd777);
    check("t6_drained", pkt_empty, 1'b1);
    cyc();
    check("t6_rd_empty_hold", pkt_rdata, 30'd777);
    pkt_ren = 1'b0;

    // Reset mid-run discards everything.
    pkt_winc = 1'b1; pkt_wdata = 30'd5; spk_valid = 2'b01; spk_id = {8'd0, 8'd30}; cyc();
    clear_inputs();
    reset_n = 1'b0; cyc();
    check("t7_empty", pkt_empty, 1'b1);
    check("t7_spk", spike_out, '0);
    check("t7_ovf", err_ovf, 1'b0);
    check("t7_rng", err_range, 1'b0);
    check("t7_state", state, S_IDLE);
    reset_n = 1'b1; cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
